sprite_motion_ctrl: RTL and testbench
=====================================

# sprite_motion_ctrl

Upstream position controller for the VGA sprite renderer. Takes four raw push-buttons and the VGA pixel counters, and produces the sprite's top-left coordinate (`x_desired`, `y_desired`) that the renderer consumes. Positions update only once per frame, at the start of vertical blank, so the sprite never tears mid-frame. The sprite is always clamped fully on-screen.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible columns.
- `V_ACTIVE`, 480: visible rows.
- `SPRITE_SIZE`, 64: sprite width and height in pixels.
- `STEP`, 4: pixels moved per frame per axis.
- `DEBOUNCE_CYCLES`, 250000: consecutive stable samples needed to accept a new button level (10 ms at 25 MHz).
- `X_INIT`, 288: `x_desired` reset value.
- `Y_INIT`, 208: `y_desired` reset value.

Ports:
- `clk`  in  1  pixel clock; the single clock for the block.
- `reset`  in  1  synchronous, active-high reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  raw asynchronous buttons, active-high.
- `x`  in  10  current VGA column counter.
- `y`  in  10  current VGA row counter.
- `x_desired`  out  10  sprite left column, registered.
- `y_desired`  out  10  sprite top row, registered.
- `frame_tick`  out  1  one-cycle pulse at the start of vertical blank, registered.

## Operation
- **Synchronizer:** each button passes through a 2-FF synchronizer.
- **Debounce:** one counter and one debounced-state register per button.
  - Synchronized level equals the debounced state → counter clears.
  - Otherwise the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while still differing, the debounced state takes the new level and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- **Frame detect:** `vb = (x == 0) && (y == V_ACTIVE)`.
  - `frame_tick` = `vb` and not previous-cycle `vb`, registered.
  - Exactly one pulse per frame, even if `x`/`y` stall on that pixel.
- **Motion FSM:** states IDLE and UPDATE.
  - IDLE → UPDATE when `frame_tick` = 1.
  - UPDATE → IDLE unconditionally. Positions are written in UPDATE.
- **X update** (in UPDATE, using the debounced left/right buttons):
  - left only: `x_desired` ← `x_desired - STEP`, or 0 if `x_desired < STEP`.
  - right only: `x_desired` ← `x_desired + STEP`, or `H_ACTIVE-SPRITE_SIZE` if the sum exceeds it.
  - both or neither: hold.
- **Y update:** same rules using up/down and `V_ACTIVE-SPRITE_SIZE`. Up decreases `y_desired`.
- **Arithmetic:** sums are computed at 11 bits before comparison, so there is no 10-bit wrap.
- **Invariants:** `x_desired ≤ H_ACTIVE-SPRITE_SIZE` and `y_desired ≤ V_ACTIVE-SPRITE_SIZE` at all times.
- **Diagonal:** both axes update in the same UPDATE cycle.
- **Reset values:** `x_desired = X_INIT`, `y_desired = Y_INIT`, `frame_tick = 0`. Also cleared: synchronizers, debounced states, counters, previous `vb`. FSM goes to IDLE.
- **Reset mid-operation:** reset in the UPDATE cycle wins; no position write occurs.

## Timing
- **Button to debounced state:** 2 synchronizer cycles + `DEBOUNCE_CYCLES` cycles.
- **Frame pulse:** `vb` true in cycle N → `frame_tick` = 1 in cycle N+1 → FSM in UPDATE in cycle N+2 → new `x_desired`/`y_desired` visible in cycle N+3.
- **Update window:** positions change only during vertical blank, never during active video.
- **Button release:** a release debounced in the same cycle as UPDATE is ignored for that frame. UPDATE samples the debounced state registered before the edge.

## Test plan
Bench uses `DEBOUNCE_CYCLES=4` and a VGA counter model of 800×525.
1. **Reset:** assert reset 3 cycles → `x_desired=288`, `y_desired=208`, `frame_tick=0`. No motion over 2 frames with buttons low.
2. **Right held:** hold `btn_right` → after the first frame `x_desired=292`. `frame_tick` pulses exactly once per 420000 cycles. `x` saturates at 576 and stays there; 10-bit wrap must never appear.
3. **Left clamp:** start at `x_desired=2` (hold left from reset), `STEP=4` → next frame 0, not 1022.
4. **Bounce rejection:** toggle `btn_up` every 2 cycles for 50 cycles, then release → `y_desired` unchanged. A glitch shorter than the debounce window is rejected.
5. **Opposing buttons:** `btn_left` and `btn_right` held together → `x_desired` holds. Adding `btn_down` → `y_desired` +4 per frame up to 416, then holds.
6. **Reset mid-operation:** assert reset in the UPDATE cycle with `btn_right` held → outputs return to 288/208 with no intermediate 292. After reset the debounce restarts, so the next move occurs at least `DEBOUNCE_CYCLES+2` cycles later.

Source files
------------

// File: rtl/sprite_motion_ctrl.sv
// rtl/sprite_motion_ctrl.sv - debounced push-button sprite position controller, updated once per frame
module sprite_motion_ctrl #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int SPRITE_SIZE     = 64,
    parameter int STEP            = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int X_INIT          = 288,
    parameter int Y_INIT          = 208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [9:0] x_desired,
    output logic [9:0] y_desired,
    output logic       frame_tick
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [10:0]   X_MAX   = 11'(H_ACTIVE - SPRITE_SIZE);
    localparam logic [10:0]   Y_MAX   = 11'(V_ACTIVE - SPRITE_SIZE);
    localparam logic [10:0]   STEP11  = 11'(STEP);
    localparam logic [9:0]    STEP10  = 10'(STEP);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_UPDATE = 1'b1;

    // Button vector order: [0]=right, [1]=left, [2]=down, [3]=up
    logic [3:0]    btn_raw;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    db_q, db_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    logic          vb;
    logic          vb_prev_q, vb_prev_d;
    logic          frame_tick_q, frame_tick_d;
    logic [0:0]    state_q, state_d;
    logic [9:0]    x_des_q, x_des_d;
    logic [9:0]    y_des_q, y_des_d;

    logic [10:0]   x_sum, y_sum;
    logic [9:0]    x_dec, y_dec;

    assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Edge detect keeps a stalled blanking pixel from producing repeated ticks
    assign vb = (x == 10'd0) && (y == 10'(V_ACTIVE));

    always_comb begin
        vb_prev_d    = vb;
        frame_tick_d = vb & ~vb_prev_q;
    end

    always_comb begin
        x_sum   = {1'b0, x_des_q} + STEP11;
        y_sum   = {1'b0, y_des_q} + STEP11;
        x_dec   = (x_des_q < STEP10) ? 10'd0 : x_des_q - STEP10;
        y_dec   = (y_des_q < STEP10) ? 10'd0 : y_des_q - STEP10;
        state_d = state_q;
        x_des_d = x_des_q;
        y_des_d = y_des_q;
        case (state_q)
            S_IDLE: begin
                if (frame_tick_q) begin
                    state_d = S_UPDATE;
                end
            end
            default: begin
                state_d = S_IDLE;
                case ({db_q[1], db_q[0]})
                    2'b10:   x_des_d = x_dec;
                    2'b01:   x_des_d = (x_sum > X_MAX) ? X_MAX[9:0] : x_sum[9:0];
                    default: x_des_d = x_des_q;
                endcase
                case ({db_q[3], db_q[2]})
                    2'b10:   y_des_d = y_dec;
                    2'b01:   y_des_d = (y_sum > Y_MAX) ? Y_MAX[9:0] : y_sum[9:0];
                    default: y_des_d = y_des_q;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_q         <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            vb_prev_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            state_q      <= S_IDLE;
            x_des_q      <= 10'(X_INIT);
            y_des_q      <= 10'(Y_INIT);
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_q         <= db_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            vb_prev_q    <= vb_prev_d;
            frame_tick_q <= frame_tick_d;
            state_q      <= state_d;
            x_des_q      <= x_des_d;
            y_des_q      <= y_des_d;
        end
    end

    assign x_desired  = x_des_q;
    assign y_desired  = y_des_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb/tb_sprite_motion_ctrl.sv - scoreboard bench for sprite_motion_ctrl (two instances, different start positions)
module tb_sprite_motion_ctrl;

    localparam int DC   = 4;
    localparam int XMAX = 576;
    localparam int YMAX = 416;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [9:0] x = '0, y = '0;
    logic [9:0] x0d, y0d, x1d, y1d;
    logic       ft0, ft1;

    always #5 clk = ~clk;

    sprite_motion_ctrl #(.DEBOUNCE_CYCLES(DC)) dut_a (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .x(x), .y(y), .x_desired(x0d), .y_desired(y0d), .frame_tick(ft0)
    );

    sprite_motion_ctrl #(.DEBOUNCE_CYCLES(DC), .X_INIT(2), .Y_INIT(2)) dut_b (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .x(x), .y(y), .x_desired(x1d), .y_desired(y1d), .frame_tick(ft1)
    );

    typedef struct {
        int ox0, oy0, ox1, oy1;
        int nx0, ny0, nx1, ny1;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int init_x [2] = '{288, 2};
    int init_y [2] = '{208, 2};
    int mx [2];
    int my [2];
    // Model buttons: [0]=right [1]=left [2]=down [3]=up
    logic [3:0] btn = '0;
    logic [3:0] last_btn = '0;
    logic [3:0] mdb = '0;
    int run [4] = '{0, 0, 0, 0};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp_v, $time);
        end
    endtask

    // A level is accepted once it has been held for the sync delay plus the debounce window
    task automatic drive_cycle(input logic [9:0] xv, input logic [9:0] yv, input logic rst);
        @(posedge clk);
        #1;
        reset = rst;
        x = xv;
        y = yv;
        {btn_up, btn_down, btn_left, btn_right} = btn;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                run[i] = 0;
                mdb[i] = 1'b0;
            end else begin
                if (btn[i] == last_btn[i]) run[i]++;
                else run[i] = 1;
                if (run[i] >= DC + 3) mdb[i] = btn[i];
            end
        end
        last_btn = btn;
    endtask

    task automatic rand_pixel(output logic [9:0] xv, output logic [9:0] yv);
        do begin
            xv = 10'($urandom_range(0, 799));
            yv = 10'($urandom_range(0, 524));
        end while (xv == 10'd0 && yv == 10'd480);
    endtask

    function automatic void step_model();
        for (int i = 0; i < 2; i++) begin
            if (mdb[1] && !mdb[0]) mx[i] = (mx[i] < 4) ? 0 : mx[i] - 4;
            if (mdb[0] && !mdb[1]) mx[i] = (mx[i] + 4 > XMAX) ? XMAX : mx[i] + 4;
            if (mdb[3] && !mdb[2]) my[i] = (my[i] < 4) ? 0 : my[i] - 4;
            if (mdb[2] && !mdb[3]) my[i] = (my[i] + 4 > YMAX) ? YMAX : my[i] + 4;
        end
    endfunction

    task automatic run_frame(input logic [3:0] b, input int lead, input int stall, input bit rst_upd);
        exp_t e;
        logic [9:0] xv, yv;
        btn = b;
        repeat (lead) begin
            rand_pixel(xv, yv);
            drive_cycle(xv, yv, 1'b0);
        end
        drive_cycle(10'd0, 10'd480, 1'b0);
        e.ox0 = mx[0]; e.oy0 = my[0]; e.ox1 = mx[1]; e.oy1 = my[1];
        if (rst_upd) begin
            mx = init_x;
            my = init_y;
        end else begin
            step_model();
        end
        e.nx0 = mx[0]; e.ny0 = my[0]; e.nx1 = mx[1]; e.ny1 = my[1];
        q.push_back(e);
        repeat (stall - 1) drive_cycle(10'd0, 10'd480, 1'b0);
        rand_pixel(xv, yv);
        drive_cycle(xv, yv, 1'b0);
        rand_pixel(xv, yv);
        drive_cycle(xv, yv, rst_upd);
        rand_pixel(xv, yv);
        drive_cycle(xv, yv, 1'b0);
    endtask

    task automatic do_reset(input int n);
        logic [9:0] xv, yv;
        repeat (n) begin
            rand_pixel(xv, yv);
            drive_cycle(xv, yv, 1'b1);
        end
        mx = init_x;
        my = init_y;
    endtask

    // Monitor: each tick pops one expectation; old values hold in UPDATE, new values appear next cycle
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && (ft0 || ft1)) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_tick actual=1 required=0 t=%0t", $time);
                end else begin
                    mon_e = q.pop_front();
                    chk("tick_a", int'(ft0), 1);
                    chk("tick_b", int'(ft1), 1);
                    @(negedge clk);
                    chk("tick_width_a", int'(ft0), 0);
                    chk("tick_width_b", int'(ft1), 0);
                    chk("hold_x_a", int'(x0d), mon_e.ox0);
                    chk("hold_y_a", int'(y0d), mon_e.oy0);
                    chk("hold_x_b", int'(x1d), mon_e.ox1);
                    chk("hold_y_b", int'(y1d), mon_e.oy1);
                    @(negedge clk);
                    chk("retick_a", int'(ft0), 0);
                    chk("retick_b", int'(ft1), 0);
                    chk("new_x_a", int'(x0d), mon_e.nx0);
                    chk("new_y_a", int'(y0d), mon_e.ny0);
                    chk("new_x_b", int'(x1d), mon_e.nx1);
                    chk("new_y_b", int'(y1d), mon_e.ny1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("x_bound_a", int'(x0d <= 10'(XMAX)), 1);
            chk("y_bound_a", int'(y0d <= 10'(YMAX)), 1);
            chk("x_bound_b", int'(x1d <= 10'(XMAX)), 1);
            chk("y_bound_b", int'(y1d <= 10'(YMAX)), 1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] xv, yv;
        mx = init_x;
        my = init_y;
        btn = '0;
        repeat (3) drive_cycle(10'd0, 10'd0, 1'b1);
        @(negedge clk);
        chk("rst_x_a", int'(x0d), 288);
        chk("rst_y_a", int'(y0d), 208);
        chk("rst_tick_a", int'(ft0), 0);
        chk("rst_x_b", int'(x1d), 2);
        chk("rst_y_b", int'(y1d), 2);
        chk("rst_tick_b", int'(ft1), 0);

        repeat (2) run_frame(4'b0000, $urandom_range(10, 20), $urandom_range(1, 3), 1'b0);
        repeat (150) run_frame(4'b0001, $urandom_range(10, 20), $urandom_range(1, 3), 1'b0);

        for (int c = 0; c < 50; c++) begin
            btn = (((c / 2) % 2) == 0) ? 4'b1000 : 4'b0000;
            rand_pixel(xv, yv);
            drive_cycle(xv, yv, 1'b0);
        end
        repeat (2) run_frame(4'b0000, $urandom_range(10, 20), $urandom_range(1, 3), 1'b0);

        repeat (5) run_frame(4'b0011, $urandom_range(10, 20), $urandom_range(1, 3), 1'b0);
        repeat (110) run_frame(4'b0111, $urandom_range(10, 20), $urandom_range(1, 3), 1'b0);
        repeat (150) run_frame(4'b0010, $urandom_range(10, 20), $urandom_range(1, 3), 1'b0);
        repeat (110) run_frame(4'b1000, $urandom_range(10, 20), $urandom_range(1, 3), 1'b0);
        repeat (200) run_frame(4'($urandom_range(0, 15)), $urandom_range(10, 20),
                               $urandom_range(1, 3), 1'b0);

        btn = 4'b0001;
        do_reset(3);
        run_frame(4'b0001, 12, 1, 1'b1);
        run_frame(4'b0001, 1, 1, 1'b0);
        repeat (3) run_frame(4'b0001, $urandom_range(10, 20), $urandom_range(1, 3), 1'b0);

        repeat (5) begin
            rand_pixel(xv, yv);
            drive_cycle(xv, yv, 1'b0);
        end
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
